ssr_tcdm_responder: RTL
=======================

SSR_TCDM_RESPONDER -- requirements
Module: ssr_tcdm_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 17: byte address width of q_addr_i.
REQ-002 SHALL have parameter DataWidth, default 64: word width; DataWidth/8 byte lanes.
REQ-003 SHALL have parameter NumWords, default 4096: memory depth in words.
REQ-004 SHALL have parameter Latency, default 2: handshake-to-response cycles; legal range 1..8, elaboration error otherwise.
REQ-005 SHALL have parameter LfsrSeed, default 16'hACE1: stall LFSR reset value; zero is an elaboration error.
REQ-006 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port stall_en_i, input, 1: enables pseudo-random request backpressure.
REQ-009 SHALL have port q_valid_i, input, 1: request valid.
REQ-010 SHALL have port q_ready_o, output, 1: request accepted when high together with q_valid_i.
REQ-011 SHALL have port q_addr_i, input, AddrWidth: byte address.
REQ-012 SHALL have port q_write_i, input, 1: 1 = write, 0 = read.
REQ-013 SHALL have port q_data_i, input, DataWidth: write data.
REQ-014 SHALL have port q_strb_i, input, DataWidth/8: per-byte write enable.
REQ-015 SHALL have port p_valid_o, output, 1: one-cycle response pulse; no ready, always consumed.
REQ-016 SHALL have port p_data_o, output, DataWidth: read data; zero for write responses.
REQ-017 SHALL have port p_err_o, output, 1: out-of-range access, qualified by p_valid_o.
REQ-018 SHALL expose memory as array "memory" of NumWords x DataWidth for hierarchical $readmemh preload.

Function
REQ-019 Handshake SHALL be q_valid_i && q_ready_o on a rising edge; at most one request per cycle.
REQ-020 Word index SHALL be q_addr_i[AddrWidth-1:$clog2(DataWidth/8)]; low address bits SHALL be ignored.
REQ-021 Index >= NumWords SHALL be out of range: write has no effect, read returns zero, p_err_o = 1 on its response.
REQ-022 In-range write SHALL update only bytes with q_strb_i set, at the handshake edge; q_strb_i = 0 is a legal no-op write.
REQ-023 Read SHALL return memory contents at the handshake cycle, including writes completed at earlier edges.
REQ-024 Every accepted request, read or write, SHALL produce exactly one p_valid_o pulse exactly Latency cycles after its handshake edge.
REQ-025 Responses SHALL be in request order; back-to-back handshakes SHALL give back-to-back responses, with no bubbles and no loss.
REQ-026 Read-after-write to the same word in consecutive cycles SHALL return the written data.
REQ-027 Response path SHALL be a Latency-deep shift pipeline of {valid, err, data}; with 1 handshake/cycle, throughput SHALL be 1 response/cycle.
REQ-028 Stall LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting every cycle regardless of stall_en_i or traffic.
REQ-029 q_ready_o SHALL be ~(stall_en_i && lfsr[0]); it SHALL NOT depend combinationally on any q_* input.
REQ-030 When stall_en_i = 0, q_ready_o SHALL be constantly 1 after reset.
REQ-031 When q_ready_o = 0, the request SHALL NOT be accepted and no state other than the LFSR SHALL change.
REQ-032 p_data_o SHALL be zero whenever p_valid_o = 0.

Reset
REQ-033 rst_i high SHALL asynchronously clear all pipeline valid, err, and data stages and set the LFSR to LfsrSeed.
REQ-034 Outputs during reset SHALL be p_valid_o = 0, p_err_o = 0, p_data_o = 0, and q_ready_o = ~(stall_en_i && LfsrSeed[0]).
REQ-035 Reset mid-operation SHALL drop all in-flight responses, with no pulse after deassertion for pre-reset requests.
REQ-036 Memory contents SHALL NOT be reset and SHALL survive rst_i.

Verification
REQ-037 Preload word 3 = 64'h1122334455667788; read at addr 'h18 -> p_valid_o exactly 2 cycles later, p_data_o = 64'h1122334455667788, p_err_o = 0.
REQ-038 Write addr 'h18, data all-ones, strb 8'h0F; read next cycle -> p_data_o = 64'h11223344FFFFFFFF; both responses on consecutive cycles.
REQ-039 Read at addr NumWords*8 -> p_data_o = 0, p_err_o = 1; a subsequent write there must leave memory unchanged.
REQ-040 100 back-to-back reads to addrs 0..99*8 with stall_en_i = 0 -> 100 consecutive p_valid_o pulses, data in order, no bubble.
REQ-041 stall_en_i = 1 with random traffic -> q_ready_o matches reference LFSR model every cycle; response count equals handshake count; scoreboard data matches.
REQ-042 Assert rst_i one cycle after 2 reads are accepted -> no p_valid_o after reset release; preloaded memory still reads correctly.

Source files
------------

// File: rtl/ssr_tcdm_responder.sv
// ssr_tcdm_responder: single-port TCDM word memory with byte strobes, a fixed
// Latency-deep response pipeline and optional pseudo-random request
// backpressure driven by a free-running 16-bit Fibonacci LFSR.
module ssr_tcdm_responder #(
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 4096,
  parameter int unsigned Latency   = 2,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_en_i,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  output logic                   p_valid_o,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   p_err_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = AddrWidth - OffW;
  localparam int unsigned MemIdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;

  if ((Latency < 1) || (Latency > 8)) begin : gen_bad_latency
    $error("ssr_tcdm_responder: Latency must be within 1..8");
  end
  if (LfsrSeed == 16'h0000) begin : gen_bad_seed
    $error("ssr_tcdm_responder: LfsrSeed must be non-zero");
  end
  if (MemIdxW > IdxW) begin : gen_bad_depth
    $error("ssr_tcdm_responder: AddrWidth too small for NumWords");
  end

  // Merge new write bytes into an existing word under a per-byte strobe.
  function automatic logic [DataWidth-1:0] mergeBytes(
    input logic [DataWidth-1:0] oldWord,
    input logic [DataWidth-1:0] newWord,
    input logic [NumBytes-1:0]  strb
  );
    logic [DataWidth-1:0] merged;
    merged = oldWord;
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = newWord[8*b +: 8];
      end else begin
        merged[8*b +: 8] = oldWord[8*b +: 8];
      end
    end
    return merged;
  endfunction

  logic [DataWidth-1:0] memory [NumWords];

  logic [15:0]          lfsr_r;
  logic                 lfsrFb_s;
  logic                 handshake_s;
  logic [IdxW-1:0]      wordIdx_s;
  logic [MemIdxW-1:0]   memIdx_s;
  logic                 inRange_s;
  logic [DataWidth-1:0] rdData_s;
  logic [DataWidth-1:0] wrMerged_s;
  logic [DataWidth-1:0] respData_s;
  logic                 unusedAddrBits_s;

  logic [Latency-1:0]   pipeValid_r;
  logic [Latency-1:0]   pipeErr_r;
  logic [DataWidth-1:0] pipeData_r [Latency];

  // Ready depends only on the stall enable and the LFSR, never on the request.
  assign q_ready_o        = ~(stall_en_i & lfsr_r[0]);
  assign unusedAddrBits_s = ^q_addr_i;

  // Decode the request: word index, range check, read data and merged write word.
  always_comb begin
    lfsrFb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    handshake_s = q_valid_i & q_ready_o;
    wordIdx_s   = q_addr_i[AddrWidth-1:OffW];
    memIdx_s    = wordIdx_s[MemIdxW-1:0];
    inRange_s   = (32'(wordIdx_s) < 32'(NumWords));
    if (inRange_s) begin
      rdData_s = memory[memIdx_s];
    end else begin
      rdData_s = '0;
    end
    wrMerged_s = mergeBytes(rdData_s, q_data_i, q_strb_i);
    if (handshake_s && !q_write_i && inRange_s) begin
      respData_s = rdData_s;
    end else begin
      respData_s = '0;
    end
  end

  // Free-running stall LFSR; shifts every cycle regardless of traffic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_r <= LfsrSeed;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsrFb_s};
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (handshake_s && q_write_i && inRange_s) begin
      memory[memIdx_s] <= wrMerged_s;
    end
  end

  // Response shift pipeline: stage 0 captures the accepted request, later stages delay it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipeValid_r <= '0;
      pipeErr_r   <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        pipeData_r[i] <= '0;
      end
    end else begin
      pipeValid_r[0] <= handshake_s;
      pipeErr_r[0]   <= handshake_s & ~inRange_s;
      pipeData_r[0]  <= respData_s;
      for (int i = 1; i < int'(Latency); i++) begin
        pipeValid_r[i] <= pipeValid_r[i-1];
        pipeErr_r[i]   <= pipeErr_r[i-1];
        pipeData_r[i]  <= pipeData_r[i-1];
      end
    end
  end

  assign p_valid_o = pipeValid_r[Latency-1];
  assign p_err_o   = pipeErr_r[Latency-1];
  assign p_data_o  = pipeData_r[Latency-1];

endmodule
